// File: rtl/op_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : op_req_sequencer
//  Description : Per-lane operand-read sequencer. Accepts one operand request
//                per handshake and emits an independent VRF word-read stream
//                (bank, row, last) for each enabled operand queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module op_req_sequencer #(
    parameter int NrQueue  = 3,
    parameter int NrLane   = 2,
    parameter int NrBank   = 8,
    parameter int WordB    = 8,
    parameter int VLEN     = 1024,
    parameter int RegWords = VLEN / NrLane / (WordB * 8),
    parameter int AddrW    = $clog2(32 * RegWords),
    parameter int VLW      = $clog2(VLEN + 1) + 3,
    localparam int BankW   = $clog2(NrBank),
    localparam int RowW    = AddrW - BankW
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [NrQueue-1:0]         req_queue_i,
    input  logic [NrQueue*5-1:0]       req_vreg_i,
    input  logic [VLW-1:0]             req_vlB_i,
    input  logic                       flush_i,
    output logic [NrQueue-1:0]         rd_valid_o,
    input  logic [NrQueue-1:0]         rd_ready_i,
    output logic [NrQueue*BankW-1:0]   rd_bank_o,
    output logic [NrQueue*RowW-1:0]    rd_row_o,
    output logic [NrQueue-1:0]         rd_last_o,
    output logic                       busy_o,
    output logic                       done_o
);

    // Bytes covered by one word across all lanes; always a power of two.
    localparam int BeatB     = NrLane * WordB;
    localparam int BeatShift = $clog2(BeatB);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [NrQueue-1:0]   mask_q, mask_d;
    logic [NrQueue-1:0]   fin_q, fin_d;
    logic [VLW-1:0]       nwords_q, nwords_d;
    logic [4:0]           vreg_q [NrQueue];
    logic [4:0]           vreg_d [NrQueue];
    logic [VLW-1:0]       idx_q  [NrQueue];
    logic [VLW-1:0]       idx_d  [NrQueue];

    logic [NrQueue-1:0]   live_w;
    logic [NrQueue-1:0]   last_w;
    logic [NrQueue-1:0]   fire_w;
    logic [VLW:0]         req_round_w;
    logic [VLW-1:0]       req_nwords_w;
    logic                 all_done_w;

    // Word count is a ceiling division by a power of two.
    assign req_round_w  = {1'b0, req_vlB_i} + (VLW+1)'(BeatB - 1);
    assign req_nwords_w = VLW'(req_round_w >> BeatShift);

    generate
        for (genvar q = 0; q < NrQueue; q++) begin : g_queue
            logic [AddrW-1:0] base_w;
            logic [AddrW-1:0] addr_w;

            // Address arithmetic wraps modulo the lane VRF size, so an LMUL
            // group starting at a high register folds back onto v0.
            assign base_w = AddrW'(vreg_q[q]) * AddrW'(RegWords);
            assign addr_w = base_w + AddrW'(idx_q[q]);

            // Banks are staggered by register number to spread conflicts.
            assign rd_bank_o[q*BankW +: BankW] = addr_w[BankW-1:0] + BankW'(vreg_q[q]);
            assign rd_row_o[q*RowW +: RowW]    = addr_w[AddrW-1:BankW];

            assign last_w[q]     = (idx_q[q] == nwords_q - VLW'(1));
            assign live_w[q]     = (state_q == ST_ISSUE) && mask_q[q] && !fin_q[q];
            assign rd_valid_o[q] = live_w[q] && !flush_i;
            assign rd_last_o[q]  = live_w[q] && last_w[q];
            assign fire_w[q]     = rd_valid_o[q] && rd_ready_i[q];
        end
    endgenerate

    // Next-state and control outputs: accept, per-queue advance, completion.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        fin_d       = fin_q;
        nwords_d    = nwords_q;
        vreg_d      = vreg_q;
        idx_d       = idx_q;
        req_ready_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        all_done_w  = 1'b1;

        case (state_q)
            ST_IDLE: begin
                req_ready_o = !flush_i;
                if (req_valid_i && !flush_i) begin
                    mask_d   = req_queue_i;
                    nwords_d = req_nwords_w;
                    fin_d    = '0;
                    for (int q = 0; q < NrQueue; q++) begin
                        vreg_d[q] = req_vreg_i[5*q +: 5];
                        idx_d[q]  = '0;
                    end
                    if ((req_nwords_w == '0) || (req_queue_i == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                busy_o = 1'b1;
                for (int q = 0; q < NrQueue; q++) begin
                    if (fire_w[q]) begin
                        // The index stays on the final word once finished.
                        if (last_w[q]) begin
                            fin_d[q] = 1'b1;
                        end else begin
                            idx_d[q] = idx_q[q] + VLW'(1);
                        end
                    end
                    if (mask_q[q] && !fin_d[q]) begin
                        all_done_w = 1'b0;
                    end
                end
                if (all_done_w) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush abandons whatever is in flight; handshakes were already gated.
        if (flush_i) begin
            state_d = ST_IDLE;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            mask_q   <= '0;
            fin_q    <= '0;
            nwords_q <= '0;
            for (int q = 0; q < NrQueue; q++) begin
                vreg_q[q] <= '0;
                idx_q[q]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            fin_q    <= fin_d;
            nwords_q <= nwords_d;
            for (int q = 0; q < NrQueue; q++) begin
                vreg_q[q] <= vreg_d[q];
                idx_q[q]  <= idx_d[q];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_op_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_op_req_sequencer
//  Description : Self-checking bench for op_req_sequencer against a
//                word-list reference model derived from the address rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_op_req_sequencer;

    localparam int NQ   = 3;
    localparam int NL   = 2;
    localparam int NB   = 8;
    localparam int WB   = 8;
    localparam int VLEN = 1024;
    localparam int RW   = VLEN / NL / (WB * 8);
    localparam int AW   = $clog2(32 * RW);
    localparam int BW   = $clog2(NB);
    localparam int ROW  = AW - BW;
    localparam int VLW  = $clog2(VLEN + 1) + 3;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [NQ-1:0]       req_queue_i;
    logic [NQ*5-1:0]     req_vreg_i;
    logic [VLW-1:0]      req_vlB_i;
    logic                flush_i;
    logic [NQ-1:0]       rd_valid_o;
    logic [NQ-1:0]       rd_ready_i;
    logic [NQ*BW-1:0]    rd_bank_o;
    logic [NQ*ROW-1:0]   rd_row_o;
    logic [NQ-1:0]       rd_last_o;
    logic                busy_o;
    logic                done_o;

    int total = 0;
    int bad   = 0;

    op_req_sequencer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_queue_i (req_queue_i),
        .req_vreg_i  (req_vreg_i),
        .req_vlB_i   (req_vlB_i),
        .flush_i     (flush_i),
        .rd_valid_o  (rd_valid_o),
        .rd_ready_i  (rd_ready_i),
        .rd_bank_o   (rd_bank_o),
        .rd_row_o    (rd_row_o),
        .rd_last_o   (rd_last_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Idle-side outputs: nothing streaming, no pulse.
    task automatic chk_quiet(input string tag, input logic exp_ready);
        chk({tag, "_valid"}, 32'(rd_valid_o), 32'd0);
        chk({tag, "_last"},  32'(rd_last_o),  32'd0);
        chk({tag, "_busy"},  32'(busy_o),     32'd0);
        chk({tag, "_done"},  32'(done_o),     32'd0);
        chk({tag, "_ready"}, 32'(req_ready_o), 32'(exp_ready));
    endtask

    // One request from accept to completion or abort.
    // abort_kind: 0 none, 1 flush, 2 reset; abort fires once abort_after
    // handshakes (summed over queues) have completed.
    task automatic run_req(input logic [NQ-1:0] mask, input logic [4:0] v0,
                           input logic [4:0] v1, input logic [4:0] v2,
                           input int vlb, input logic [NQ-1:0] stall,
                           input int abort_kind, input int abort_after);
        int          n;
        int          cnt [NQ];
        int          hs;
        int          a;
        logic [4:0]  vr [NQ];
        bit          aborting;
        bit          ev;
        bit          all_fin;
        bit          finished;
        logic [NQ-1:0] fire;

        n     = (vlb + NL*WB - 1) / (NL*WB);
        vr[0] = v0;
        vr[1] = v1;
        vr[2] = v2;
        hs    = 0;
        finished = 1'b0;
        for (int q = 0; q < NQ; q++) cnt[q] = 0;

        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_queue_i = mask;
        req_vreg_i  = {v2, v1, v0};
        req_vlB_i   = VLW'(vlb);
        #1;
        chk("accept_ready", 32'(req_ready_o), 32'd1);

        @(negedge clk_i);
        req_valid_i = 1'b0;
        req_queue_i = NQ'($urandom);
        req_vreg_i  = (NQ*5)'($urandom);
        req_vlB_i   = VLW'($urandom);

        if (n == 0 || mask == '0) begin
            #1;
            chk("empty_done",  32'(done_o),      32'd1);
            chk("empty_busy",  32'(busy_o),      32'd0);
            chk("empty_ready", 32'(req_ready_o), 32'd0);
            chk("empty_valid", 32'(rd_valid_o),  32'd0);
            @(negedge clk_i);
            #1;
            chk_quiet("empty_after", 1'b1);
            return;
        end

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (cyc > 0) @(negedge clk_i);
            for (int q = 0; q < NQ; q++)
                rd_ready_i[q] = stall[q] ? 1'($urandom_range(0, 1)) : 1'b1;
            aborting = (abort_kind != 0) && (hs >= abort_after);
            flush_i  = (abort_kind == 1) && aborting;
            rst_i    = (abort_kind == 2) && aborting;
            #1;
            for (int q = 0; q < NQ; q++) begin
                ev = mask[q] && (cnt[q] < n) && !flush_i;
                chk("rd_valid", 32'(rd_valid_o[q]), 32'(ev));
                if (ev) begin
                    a = (int'(vr[q]) * RW + cnt[q]) % (1 << AW);
                    chk("rd_bank", 32'(rd_bank_o[q*BW +: BW]),  32'((a + int'(vr[q])) % NB));
                    chk("rd_row",  32'(rd_row_o[q*ROW +: ROW]), 32'(a / NB));
                    chk("rd_last", 32'(rd_last_o[q]),           32'(cnt[q] == n - 1));
                end
                fire[q] = ev && rd_ready_i[q];
            end
            chk("issue_busy",  32'(busy_o),      32'd1);
            chk("issue_done",  32'(done_o),      32'd0);
            chk("issue_ready", 32'(req_ready_o), 32'd0);

            if (aborting) begin
                @(negedge clk_i);
                flush_i = 1'b0;
                #1;
                chk_quiet("abort_after", 1'b1);
                rst_i = 1'b0;
                finished = 1'b1;
                break;
            end

            for (int q = 0; q < NQ; q++) if (fire[q]) cnt[q]++;
            hs += $countones(fire);
            all_fin = 1'b1;
            for (int q = 0; q < NQ; q++) if (mask[q] && cnt[q] < n) all_fin = 1'b0;

            if (all_fin) begin
                @(negedge clk_i);
                #1;
                chk("fin_done",  32'(done_o),      32'd1);
                chk("fin_busy",  32'(busy_o),      32'd0);
                chk("fin_ready", 32'(req_ready_o), 32'd0);
                chk("fin_valid", 32'(rd_valid_o),  32'd0);
                @(negedge clk_i);
                #1;
                chk_quiet("fin_after", 1'b1);
                finished = 1'b1;
                break;
            end
        end
        chk("stream_complete", 32'(finished), 32'd1);
    endtask

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_queue_i = '0;
        req_vreg_i  = '0;
        req_vlB_i   = '0;
        flush_i     = 1'b0;
        rd_ready_i  = '1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk_quiet("reset", 1'b1);
        rst_i = 1'b0;

        // Two queues, N=4, no stalls.
        run_req(3'b011, 5'd2, 5'd5, 5'd0, 64, 3'b000, 0, 0);
        // Long stream on the store queue, then one that wraps past v31.
        run_req(3'b100, 5'd0, 5'd0, 5'd24, 1024, 3'b000, 0, 0);
        run_req(3'b100, 5'd0, 5'd0, 5'd31, 1024, 3'b000, 0, 0);
        // Stalls on queue 1 only.
        run_req(3'b011, 5'd1, 5'd7, 5'd0, 48, 3'b010, 0, 0);
        // Degenerate requests and a non-multiple length.
        run_req(3'b111, 5'd3, 5'd4, 5'd5, 0, 3'b000, 0, 0);
        run_req(3'b000, 5'd3, 5'd4, 5'd5, 64, 3'b000, 0, 0);
        run_req(3'b111, 5'd10, 5'd20, 5'd30, 17, 3'b000, 0, 0);
        // Flush after two handshakes, then a clean restart.
        run_req(3'b001, 5'd3, 5'd0, 5'd0, 64, 3'b000, 1, 2);
        run_req(3'b001, 5'd3, 5'd0, 5'd0, 64, 3'b000, 0, 0);
        // Reset mid-stream, then a clean request.
        run_req(3'b111, 5'd4, 5'd9, 5'd30, 256, 3'b111, 2, 3);
        run_req(3'b111, 5'd4, 5'd9, 5'd30, 256, 3'b101, 0, 0);

        // Flush in idle must block acceptance.
        @(negedge clk_i);
        req_valid_i = 1'b1;
        req_queue_i = 3'b001;
        req_vlB_i   = VLW'(64);
        flush_i     = 1'b1;
        #1;
        chk("idle_flush_ready", 32'(req_ready_o), 32'd0);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        #1;
        chk_quiet("idle_flush_after", 1'b1);

        // Randomised requests with random stall patterns.
        for (int k = 0; k < 24; k++) begin
            run_req(NQ'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    int'($urandom_range(0, 2048)), NQ'($urandom), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
